// File: rtl/falafel_pkg.sv
// Shared types for the allocator free-list walker and its load/store unit.
// Combinational only: no state lives here.
// No flow control: types, constants and one address helper.
package falafel_pkg;

    // Byte offset of the next_addr word inside a free block header.
    localparam logic [63:0] BLOCK_NEXT_ADDR_OFFSET = 64'd8;

    // Values of the free-list lock word.
    localparam logic [63:0] LOCK_FREE = 64'd0;
    localparam logic [63:0] LOCK_HELD = 64'd1;

    typedef enum logic [2:0] {
        LOCK                    = 3'd0,
        UNLOCK                  = 3'd1,
        LOAD                    = 3'd2,
        EDIT_SIZE_AND_NEXT_ADDR = 3'd3,
        EDIT_NEXT_ADDR          = 3'd4
    } req_lsu_op_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [63:0] size;
        logic [63:0] next_addr;
    } header_t;

    typedef struct packed {
        logic        val;
        req_lsu_op_t lsu_op;
        header_t     header;
    } header_req_t;

    typedef struct packed {
        logic    val;
        header_t header;
    } header_rsp_t;

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        RD_SZ   = 4'd1,
        RD_SZ_W = 4'd2,
        RD_NX   = 4'd3,
        RD_NX_W = 4'd4,
        WR_SZ   = 4'd5,
        WR_NX   = 4'd6,
        LK_RD   = 4'd7,
        LK_RD_W = 4'd8,
        LK_WR   = 4'd9,
        UL_WR   = 4'd10,
        RSP     = 4'd11
    } lsu_state_t;

    typedef struct packed {
        logic        req;
        logic        we;
        logic        lock;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

    // Address of a block's next_addr word; wraps modulo 2^64.
    function automatic logic [63:0] next_addr_of(input logic [63:0] a);
        return a + BLOCK_NEXT_ADDR_OFFSET;
    endfunction

endpackage

// File: rtl/falafel_lsu.sv
// Load/store unit: turns free-list header commands into single 64-bit memory accesses.
// Latency (zero-wait memory): LOAD 5, EDIT_SIZE_AND_NEXT_ADDR 3, EDIT_NEXT_ADDR 2, UNLOCK 2, LOCK 4.
// One command in flight; req_ready_o low until the response is taken; memory outputs held until granted.
module falafel_lsu
    import falafel_pkg::*;
#(
    parameter logic [63:0] LOCK_ADDR = 64'h0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  header_req_t req_i,
    output logic        req_ready_o,
    output header_rsp_t rsp_o,
    input  logic        rsp_ready_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic        mem_lock_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [63:0] mem_rdata_i
);

    lsu_state_t state_q, state_d;
    header_t    hdr_q, hdr_d;
    mem_req_t   mem_q, mem_d;
    logic       rsp_vld_q, rsp_vld_d;
    logic       req_rdy_q, req_rdy_d;
    header_t    rsp_hdr;

    // Memory access driven while sitting in state s. Reads and writes of the
    // lock word carry the bus lock; the unlock write deliberately does not.
    function automatic mem_req_t issue(input lsu_state_t s, input header_t h);
        mem_req_t m;
        m     = '0;
        m.req = 1'b1;
        case (s)
            RD_SZ: m.addr = h.addr;
            RD_NX: m.addr = next_addr_of(h.addr);
            WR_SZ: begin
                m.we    = 1'b1;
                m.addr  = h.addr;
                m.wdata = h.size;
            end
            WR_NX: begin
                m.we    = 1'b1;
                m.addr  = next_addr_of(h.addr);
                m.wdata = h.next_addr;
            end
            LK_RD: begin
                m.lock = 1'b1;
                m.addr = LOCK_ADDR;
            end
            LK_WR: begin
                m.we    = 1'b1;
                m.lock  = 1'b1;
                m.addr  = LOCK_ADDR;
                m.wdata = LOCK_HELD;
            end
            UL_WR: begin
                m.we    = 1'b1;
                m.addr  = LOCK_ADDR;
                m.wdata = LOCK_FREE;
            end
            default: m = '0;
        endcase
        return m;
    endfunction

    // Next-state and registered-output logic of the command FSM.
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        mem_d     = mem_q;
        rsp_vld_d = rsp_vld_q;
        req_rdy_d = req_rdy_q;

        // A granted access is finished on the bus; the request drops next cycle
        // unless a state below immediately issues the following access.
        if (mem_q.req && mem_gnt_i) begin
            mem_d.req = 1'b0;
        end

        case (state_q)
            IDLE: begin
                req_rdy_d = 1'b1;
                if (req_i.val && req_rdy_q) begin
                    req_rdy_d = 1'b0;
                    hdr_d     = req_i.header;
                    case (req_i.lsu_op)
                        LOAD:                    state_d = RD_SZ;
                        EDIT_SIZE_AND_NEXT_ADDR: state_d = WR_SZ;
                        EDIT_NEXT_ADDR:          state_d = WR_NX;
                        UNLOCK:                  state_d = UL_WR;
                        LOCK:                    state_d = LK_RD;
                        default: begin
                            state_d   = RSP;
                            rsp_vld_d = 1'b1;
                        end
                    endcase
                end
            end

            // Access states: raise the request if the bus is idle, advance on grant.
            RD_SZ, RD_NX, WR_SZ, WR_NX, UL_WR, LK_RD, LK_WR: begin
                if (!mem_q.req) begin
                    mem_d = issue(state_q, hdr_q);
                end else if (mem_gnt_i) begin
                    case (state_q)
                        RD_SZ: state_d = RD_SZ_W;
                        RD_NX: state_d = RD_NX_W;
                        LK_RD: state_d = LK_RD_W;
                        WR_SZ: begin
                            state_d = WR_NX;
                            mem_d   = issue(WR_NX, hdr_q);
                        end
                        LK_WR: begin
                            state_d    = RSP;
                            rsp_vld_d  = 1'b1;
                            mem_d.lock = 1'b0;
                        end
                        default: begin
                            state_d   = RSP;
                            rsp_vld_d = 1'b1;
                        end
                    endcase
                end
            end

            RD_SZ_W: begin
                if (mem_rvalid_i) begin
                    hdr_d.size = mem_rdata_i;
                    state_d    = RD_NX;
                    mem_d      = issue(RD_NX, hdr_q);
                end
            end

            RD_NX_W: begin
                if (mem_rvalid_i) begin
                    hdr_d.next_addr = mem_rdata_i;
                    state_d         = RSP;
                    rsp_vld_d       = 1'b1;
                end
            end

            // Lock held by someone else: release the bus lock for one cycle so
            // other masters can get in, then re-read.
            LK_RD_W: begin
                if (mem_rvalid_i) begin
                    if (mem_rdata_i == LOCK_FREE) begin
                        state_d = LK_WR;
                        mem_d   = issue(LK_WR, hdr_q);
                    end else begin
                        state_d    = LK_RD;
                        mem_d.lock = 1'b0;
                    end
                end
            end

            RSP: begin
                if (rsp_vld_q && rsp_ready_i) begin
                    state_d   = IDLE;
                    rsp_vld_d = 1'b0;
                    req_rdy_d = 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any command in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            mem_q     <= '0;
            rsp_vld_q <= 1'b0;
            req_rdy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            mem_q     <= mem_d;
            rsp_vld_q <= rsp_vld_d;
            req_rdy_q <= req_rdy_d;
        end
    end

    assign rsp_hdr     = rsp_vld_q ? hdr_q : '0;
    assign rsp_o       = '{val: rsp_vld_q, header: rsp_hdr};
    assign req_ready_o = req_rdy_q;
    assign mem_req_o   = mem_q.req;
    assign mem_we_o    = mem_q.we;
    assign mem_lock_o  = mem_q.lock;
    assign mem_addr_o  = mem_q.addr;
    assign mem_wdata_o = mem_q.wdata;

endmodule

// File: tb/tb_falafel_lsu.sv
// Directed bench for falafel_lsu with a memory responder on the falling edge.
// Responder grants after a configurable stall and returns read data one cycle after grant.
// Each test task checks latency, bus traffic, response contents and handshake behaviour.
module tb_falafel_lsu;
    import falafel_pkg::*;

    typedef struct packed {
        logic        we;
        logic        lock;
        logic [63:0] addr;
        logic [63:0] wdata;
    } acc_t;

    logic        clk;
    logic        rst_ni;
    header_req_t req_i;
    logic        req_ready_o;
    header_rsp_t rsp_o;
    logic        rsp_ready_i;
    logic        mem_req_o, mem_we_o, mem_lock_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [63:0] mem_rdata_i;

    int nvec  = 0;
    int nfail = 0;

    // Test-owned memory configuration.
    logic [63:0] mem [logic [63:0]];
    logic [63:0] lk_seq [8];
    int          lk_len   = 0;
    int          lk_base  = 0;
    int          stall_idx = -1;
    int          stall_len = 0;
    int          hold_viol = 0;
    logic [63:0] lock_trace;

    // Responder-owned state.
    acc_t        acc_log [$];
    int          acc_cnt    = 0;
    int          cur_wait   = 0;
    int          lk_rds     = 0;
    logic        rd_pending = 1'b0;
    logic [63:0] rd_data    = '0;

    falafel_lsu #(.LOCK_ADDR(64'h0)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .req_i        (req_i),
        .req_ready_o  (req_ready_o),
        .rsp_o        (rsp_o),
        .rsp_ready_i  (rsp_ready_i),
        .mem_req_o    (mem_req_o),
        .mem_we_o     (mem_we_o),
        .mem_lock_o   (mem_lock_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_gnt_i    (mem_gnt_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: decisions made on the falling edge, sampled by the DUT on the rising edge.
    always @(negedge clk) begin
        int idx;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        if (rd_pending) begin
            mem_rvalid_i = 1'b1;
            mem_rdata_i  = rd_data;
            rd_pending   = 1'b0;
        end
        mem_gnt_i = 1'b0;
        if (mem_req_o === 1'b1) begin
            if (acc_cnt == stall_idx && cur_wait < stall_len) begin
                cur_wait++;
            end else begin
                mem_gnt_i = 1'b1;
                cur_wait  = 0;
                acc_cnt++;
                acc_log.push_back('{we: mem_we_o, lock: mem_lock_o, addr: mem_addr_o, wdata: mem_wdata_o});
                if (!mem_we_o) begin
                    rd_pending = 1'b1;
                    idx = lk_rds - lk_base;
                    if (mem_addr_o == 64'h0 && idx < lk_len) begin
                        rd_data = lk_seq[idx];
                        lk_rds++;
                    end else begin
                        rd_data = mem.exists(mem_addr_o) ? mem[mem_addr_o] : 64'h0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Issue one command and count cycles from the acceptance edge to rsp_o.val (-1 on timeout).
    task automatic send_cmd(input req_lsu_op_t op, input logic [63:0] a, input logic [63:0] sz,
                            input logic [63:0] nx, output int lat);
        int          w;
        logic        p_req, p_we;
        logic [63:0] p_addr, p_wdata;
        lat = -1;
        w   = 0;
        while (req_ready_o !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (req_ready_o !== 1'b1) return;
        req_i = '{val: 1'b1, lsu_op: op, header: '{addr: a, size: sz, next_addr: nx}};
        @(posedge clk); #1;
        req_i.val     = 1'b0;
        lock_trace    = '0;
        lock_trace[0] = mem_lock_o;
        p_req = mem_req_o; p_we = mem_we_o; p_addr = mem_addr_o; p_wdata = mem_wdata_o;
        if (rsp_o.val === 1'b1) begin
            lat = 0;
            return;
        end
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            lock_trace[n] = mem_lock_o;
            if (p_req && mem_gnt_i !== 1'b1 &&
                (mem_req_o !== 1'b1 || mem_addr_o !== p_addr || mem_we_o !== p_we || mem_wdata_o !== p_wdata))
                hold_viol++;
            p_req = mem_req_o; p_we = mem_we_o; p_addr = mem_addr_o; p_wdata = mem_wdata_o;
            if (rsp_o.val === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; rsp_ready_i = 1'b1; req_i = '0;
        repeat (2) next_cycle();
        nvec++; if (req_ready_o !== 1'b0) begin nfail++; $display("FAIL reset_req_ready: got %b, expected 0", req_ready_o); end
        nvec++; if ({mem_req_o, mem_we_o, mem_lock_o} !== 3'b000) begin nfail++; $display("FAIL reset_mem_ctl: got %b, expected 000", {mem_req_o, mem_we_o, mem_lock_o}); end
        nvec++; if ({mem_addr_o, mem_wdata_o} !== 128'h0) begin nfail++; $display("FAIL reset_mem_data: got %h, expected 0", {mem_addr_o, mem_wdata_o}); end
        nvec++; if (rsp_o !== '0) begin nfail++; $display("FAIL reset_rsp: got %h, expected 0", rsp_o); end
        rst_ni = 1'b1;
        next_cycle();
        nvec++; if (req_ready_o !== 1'b1) begin nfail++; $display("FAIL reset_release_ready: got %b, expected 1", req_ready_o); end
    endtask

    task automatic test_load();
        int lat, base;
        header_t exp;
        base = acc_log.size();
        mem[64'h100] = 64'h40;
        mem[64'h108] = 64'h200;
        send_cmd(LOAD, 64'h100, 64'hDEAD, 64'hBEEF, lat);
        exp = '{addr: 64'h100, size: 64'h40, next_addr: 64'h200};
        nvec++; if (lat !== 5) begin nfail++; $display("FAIL load_latency: got %0d, expected 5", lat); end
        nvec++; if (rsp_o.header !== exp) begin nfail++; $display("FAIL load_rsp: got %h, expected %h", rsp_o.header, exp); end
        nvec++; if (acc_log.size() - base !== 2) begin nfail++; $display("FAIL load_access_count: got %0d, expected 2", acc_log.size() - base); end
        nvec++; if (acc_log[base] !== acc_t'{we: 1'b0, lock: 1'b0, addr: 64'h100, wdata: 64'h0}) begin nfail++; $display("FAIL load_rd0: got %h, expected read @100", acc_log[base]); end
        nvec++; if (acc_log[base+1] !== acc_t'{we: 1'b0, lock: 1'b0, addr: 64'h108, wdata: 64'h0}) begin nfail++; $display("FAIL load_rd1: got %h, expected read @108", acc_log[base+1]); end
        next_cycle();
        nvec++; if ({rsp_o.val, req_ready_o} !== 2'b01) begin nfail++; $display("FAIL load_handshake: got val/ready %b, expected 01", {rsp_o.val, req_ready_o}); end
    endtask

    task automatic test_edit_size_next();
        int lat, base;
        header_t exp;
        base = acc_log.size();
        send_cmd(EDIT_SIZE_AND_NEXT_ADDR, 64'h200, 64'h20, 64'h0, lat);
        exp = '{addr: 64'h200, size: 64'h20, next_addr: 64'h0};
        nvec++; if (lat !== 3) begin nfail++; $display("FAIL esn_latency: got %0d, expected 3", lat); end
        nvec++; if (acc_log.size() - base !== 2) begin nfail++; $display("FAIL esn_access_count: got %0d, expected 2", acc_log.size() - base); end
        nvec++; if (acc_log[base] !== acc_t'{we: 1'b1, lock: 1'b0, addr: 64'h200, wdata: 64'h20}) begin nfail++; $display("FAIL esn_wr0: got %h, expected write 20@200", acc_log[base]); end
        nvec++; if (acc_log[base+1] !== acc_t'{we: 1'b1, lock: 1'b0, addr: 64'h208, wdata: 64'h0}) begin nfail++; $display("FAIL esn_wr1: got %h, expected write 0@208", acc_log[base+1]); end
        nvec++; if (rsp_o.header !== exp) begin nfail++; $display("FAIL esn_rsp: got %h, expected %h", rsp_o.header, exp); end
        next_cycle();
    endtask

    task automatic test_lock_spin();
        int lat, base, good_rds;
        header_t exp;
        base = acc_log.size();
        lk_seq[0] = 64'd1; lk_seq[1] = 64'd1; lk_seq[2] = 64'd1; lk_seq[3] = 64'd0;
        lk_base = lk_rds; lk_len = 4;
        send_cmd(LOCK, 64'h40, 64'h11, 64'h22, lat);
        exp = '{addr: 64'h40, size: 64'h11, next_addr: 64'h22};
        nvec++; if (lat !== 13) begin nfail++; $display("FAIL lock_latency: got %0d, expected 13", lat); end
        nvec++; if (lock_trace[13:0] !== 14'h1DB6) begin nfail++; $display("FAIL lock_trace: got %b, expected %b", lock_trace[13:0], 14'h1DB6); end
        nvec++; if (acc_log.size() - base !== 5) begin nfail++; $display("FAIL lock_access_count: got %0d, expected 5", acc_log.size() - base); end
        good_rds = 0;
        for (int i = 0; i < 4; i++)
            if (acc_log[base+i] === acc_t'{we: 1'b0, lock: 1'b1, addr: 64'h0, wdata: 64'h0}) good_rds++;
        nvec++; if (good_rds !== 4) begin nfail++; $display("FAIL lock_reads: got %0d locked reads @0, expected 4", good_rds); end
        nvec++; if (acc_log[base+4] !== acc_t'{we: 1'b1, lock: 1'b1, addr: 64'h0, wdata: 64'h1}) begin nfail++; $display("FAIL lock_write: got %h, expected locked write 1@0", acc_log[base+4]); end
        nvec++; if (rsp_o.header !== exp) begin nfail++; $display("FAIL lock_rsp: got %h, expected %h", rsp_o.header, exp); end
        next_cycle();
        nvec++; if ({rsp_o.val, mem_lock_o} !== 2'b00) begin nfail++; $display("FAIL lock_single_rsp: got val/lock %b, expected 00", {rsp_o.val, mem_lock_o}); end
        lk_len = 0;
        base = acc_log.size();
        send_cmd(UNLOCK, 64'h40, 64'h0, 64'h0, lat);
        nvec++; if (lat !== 2) begin nfail++; $display("FAIL unlock_latency: got %0d, expected 2", lat); end
        nvec++; if (acc_log[base] !== acc_t'{we: 1'b1, lock: 1'b0, addr: 64'h0, wdata: 64'h0}) begin nfail++; $display("FAIL unlock_write: got %h, expected write 0@0", acc_log[base]); end
        next_cycle();
    endtask

    task automatic test_gnt_backpressure();
        int lat;
        header_t exp;
        hold_viol = 0;
        stall_idx = acc_cnt; stall_len = 3;
        send_cmd(LOAD, 64'h100, 64'h0, 64'h0, lat);
        stall_idx = -1;
        exp = '{addr: 64'h100, size: 64'h40, next_addr: 64'h200};
        nvec++; if (lat !== 8) begin nfail++; $display("FAIL gnt_bp_latency: got %0d, expected 8", lat); end
        nvec++; if (hold_viol !== 0) begin nfail++; $display("FAIL gnt_bp_hold: got %0d unstable cycles, expected 0", hold_viol); end
        nvec++; if (rsp_o.header !== exp) begin nfail++; $display("FAIL gnt_bp_rsp: got %h, expected %h", rsp_o.header, exp); end
        next_cycle();
    endtask

    task automatic test_rsp_backpressure();
        int lat, base, bad;
        header_rsp_t held;
        base = acc_log.size();
        rsp_ready_i = 1'b0;
        send_cmd(EDIT_NEXT_ADDR, 64'h300, 64'h9, 64'h500, lat);
        nvec++; if (lat !== 2) begin nfail++; $display("FAIL rsp_bp_latency: got %0d, expected 2", lat); end
        nvec++; if (acc_log[base] !== acc_t'{we: 1'b1, lock: 1'b0, addr: 64'h308, wdata: 64'h500}) begin nfail++; $display("FAIL rsp_bp_write: got %h, expected write 500@308", acc_log[base]); end
        held = rsp_o;
        bad  = 0;
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            if (rsp_o !== held || req_ready_o !== 1'b0 || rsp_o.val !== 1'b1) bad++;
        end
        nvec++; if (bad !== 0) begin nfail++; $display("FAIL rsp_bp_hold: got %0d unstable cycles, expected 0", bad); end
        rsp_ready_i = 1'b1;
        next_cycle();
        nvec++; if ({rsp_o.val, req_ready_o} !== 2'b01) begin nfail++; $display("FAIL rsp_bp_release: got val/ready %b, expected 01", {rsp_o.val, req_ready_o}); end
    endtask

    task automatic test_wrap();
        int lat, base;
        base = acc_log.size();
        send_cmd(EDIT_NEXT_ADDR, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h77, lat);
        nvec++; if (lat !== 2) begin nfail++; $display("FAIL wrap_latency: got %0d, expected 2", lat); end
        nvec++; if (acc_log[base] !== acc_t'{we: 1'b1, lock: 1'b0, addr: 64'h0, wdata: 64'h77}) begin nfail++; $display("FAIL wrap_write: got %h, expected write 77@0", acc_log[base]); end
        next_cycle();
    endtask

    task automatic test_unknown_op();
        int lat, base;
        header_t exp;
        base = acc_log.size();
        send_cmd(req_lsu_op_t'(3'd7), 64'h500, 64'h5, 64'h6, lat);
        exp = '{addr: 64'h500, size: 64'h5, next_addr: 64'h6};
        nvec++; if (lat < 0 || rsp_o.header !== exp) begin nfail++; $display("FAIL unknown_rsp: got lat %0d hdr %h, expected echo %h", lat, rsp_o.header, exp); end
        nvec++; if (acc_log.size() - base !== 0) begin nfail++; $display("FAIL unknown_no_access: got %0d accesses, expected 0", acc_log.size() - base); end
        next_cycle();
    endtask

    task automatic test_reset_abort();
        int lat, seen;
        header_t exp;
        // Abort while waiting for lock read data.
        lk_seq[0] = 64'd1; lk_seq[1] = 64'd1; lk_seq[2] = 64'd1; lk_seq[3] = 64'd1;
        lk_base = lk_rds; lk_len = 4;
        req_i = '{val: 1'b1, lsu_op: LOCK, header: '{addr: 64'h0, size: 64'h0, next_addr: 64'h0}};
        next_cycle();
        req_i.val = 1'b0;
        next_cycle();
        next_cycle();
        nvec++; if ({mem_req_o, mem_lock_o} !== 2'b01) begin nfail++; $display("FAIL abort_pre_lock: got req/lock %b, expected 01", {mem_req_o, mem_lock_o}); end
        rst_ni = 1'b0;
        #1;
        nvec++; if ({mem_req_o, mem_lock_o, req_ready_o, rsp_o.val} !== 4'b0000) begin nfail++; $display("FAIL abort_lkw_outputs: got %b, expected 0000", {mem_req_o, mem_lock_o, req_ready_o, rsp_o.val}); end
        seen = 0;
        repeat (2) begin next_cycle(); if (rsp_o.val !== 1'b0 || mem_req_o !== 1'b0) seen++; end
        rst_ni = 1'b1;
        lk_len = 0;
        next_cycle();
        if (rsp_o.val !== 1'b0 || mem_req_o !== 1'b0) seen++;
        nvec++; if (seen !== 0) begin nfail++; $display("FAIL abort_lkw_quiet: got %0d active cycles, expected 0", seen); end
        nvec++; if (req_ready_o !== 1'b1) begin nfail++; $display("FAIL abort_lkw_ready: got %b, expected 1", req_ready_o); end
        // Abort while the response is waiting for the consumer.
        rsp_ready_i = 1'b0;
        send_cmd(UNLOCK, 64'h0, 64'h0, 64'h0, lat);
        nvec++; if (lat !== 2) begin nfail++; $display("FAIL abort_rsp_setup: got %0d, expected 2", lat); end
        rst_ni = 1'b0;
        #1;
        nvec++; if ({rsp_o.val, req_ready_o, mem_req_o} !== 3'b000) begin nfail++; $display("FAIL abort_rsp_outputs: got %b, expected 000", {rsp_o.val, req_ready_o, mem_req_o}); end
        next_cycle();
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        next_cycle();
        nvec++; if ({rsp_o.val, req_ready_o} !== 2'b01) begin nfail++; $display("FAIL abort_rsp_release: got val/ready %b, expected 01", {rsp_o.val, req_ready_o}); end
        mem[64'h300] = 64'h11;
        mem[64'h308] = 64'h22;
        send_cmd(LOAD, 64'h300, 64'h0, 64'h0, lat);
        exp = '{addr: 64'h300, size: 64'h11, next_addr: 64'h22};
        nvec++; if (lat !== 5 || rsp_o.header !== exp) begin nfail++; $display("FAIL abort_followup_load: got lat %0d hdr %h, expected 5 %h", lat, rsp_o.header, exp); end
        next_cycle();
    endtask

    initial begin
        rst_ni       = 1'b0;
        req_i        = '0;
        rsp_ready_i  = 1'b1;
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        test_reset();
        test_load();
        test_edit_size_next();
        test_lock_spin();
        test_gnt_backpressure();
        test_rsp_backpressure();
        test_wrap();
        test_unknown_op();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
